pc_sequencer: RTL and testbench

Parametrised program-counter sequencer for the next core generation; replaces the fixed PC + hard-wired jump LUT pair. Adds a req/done run handshake, a run-time-programmable branch-target LUT with absolute or PC-relative mode, a call/return stack, stall and halt. Sits between instruction fetch (drives instruction ROM address) and the control decoder (supplies branch/call/ret/halt/stall and LUT index).

---
 rtl/pc_sequencer.sv | 127 ++++++++++++
 tb/tb_pc_sequencer.sv | 341 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/pc_sequencer.sv
// Program-counter sequencer: req/done run control, programmable branch LUT, call/return stack.
// Control inputs take effect on prog_ctr at the next rising edge; stall freezes PC and stack.
module pc_sequencer #(
  parameter int D        = 10,
  parameter int LW       = 3,
  parameter int SD       = 4,
  parameter int REL      = 0,
  parameter int START_PC = 0,
  parameter int HALT_PC  = 128
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          req,
  input  logic          stall,
  input  logic          branch,
  input  logic          call,
  input  logic          ret,
  input  logic          halt,
  input  logic [LW-1:0] lut_idx,
  input  logic          lut_wr_en,
  input  logic [LW-1:0] lut_wr_idx,
  input  logic [D-1:0]  lut_wr_data,
  output logic [D-1:0]  prog_ctr,
  output logic          busy,
  output logic          done,
  output logic          stack_err
);

  localparam int SPW = $clog2(SD + 1);
  localparam int IW  = (SD > 1) ? $clog2(SD) : 1;

  typedef enum logic [1:0] {IDLE = 2'd0, RUN = 2'd1, DONE = 2'd2} state_t;

  state_t         state, state_n;
  logic [D-1:0]   lut   [0:2**LW-1];
  logic [D-1:0]   stack [0:2**IW-1];
  logic [SPW-1:0] sp, sp_n;
  logic [D-1:0]   pc_n, pc_inc, target, lut_val, top;
  logic           err_n, push;
  logic [IW-1:0]  push_idx, top_idx;

  // Same-cycle LUT writes land on the edge, so reads here still see the old entry.
  assign lut_val  = lut[lut_idx];
  assign pc_inc   = prog_ctr + D'(1);
  assign target   = (REL != 0) ? prog_ctr + lut_val : lut_val;
  assign top_idx  = IW'(sp - SPW'(1));
  assign push_idx = IW'(sp);
  assign top      = stack[top_idx];

  assign busy = (state == RUN);
  assign done = (state == DONE);

  always_comb begin
    state_n = state;
    pc_n    = prog_ctr;
    sp_n    = sp;
    err_n   = stack_err;
    push    = 1'b0;
    case (state)
      IDLE, DONE: begin
        if (req) begin
          state_n = RUN;
          pc_n    = D'(START_PC);
          sp_n    = '0;
          err_n   = 1'b0;
        end
      end
      RUN: begin
        // Reaching HALT_PC completes even while stalled; a decoded halt does not.
        if (prog_ctr == D'(HALT_PC) || (halt && !stall)) begin
          state_n = DONE;
        end else if (!stall) begin
          if (ret) begin
            if (sp != '0) begin
              pc_n = top;
              sp_n = sp - SPW'(1);
            end else begin
              err_n = 1'b1;
              pc_n  = pc_inc;
            end
          end else if (call) begin
            if (sp != SPW'(SD)) begin
              push = 1'b1;
              sp_n = sp + SPW'(1);
              pc_n = target;
            end else begin
              err_n = 1'b1;
              pc_n  = pc_inc;
            end
          end else if (branch) begin
            pc_n = target;
          end else begin
            pc_n = pc_inc;
          end
        end
      end
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state     <= IDLE;
      prog_ctr  <= '0;
      sp        <= '0;
      stack_err <= 1'b0;
    end else begin
      state     <= state_n;
      prog_ctr  <= pc_n;
      sp        <= sp_n;
      stack_err <= err_n;
    end
  end

  always_ff @(posedge clk) begin
    if (push) stack[push_idx] <= pc_inc;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < 2**LW; i++) lut[i] <= '0;
    end else if (lut_wr_en) begin
      lut[lut_wr_idx] <= lut_wr_data;
    end
  end

endmodule

// File: tb/tb_pc_sequencer.sv
// Bench for pc_sequencer: absolute and PC-relative instances share stimulus and are
// compared each cycle against a queue/array model, plus a directed vector table.
module tb_pc_sequencer;

  localparam int D = 10, LW = 3, SD = 4, HALT = 128, MOD = 1024;

  logic clk = 0, reset = 0;
  logic req = 0, stall = 0, branch = 0, call = 0, ret = 0, halt = 0, lut_wr_en = 0;
  logic [LW-1:0] lut_idx = '0, lut_wr_idx = '0;
  logic [D-1:0]  lut_wr_data = '0;
  logic [D-1:0]  pc_a, pc_r;
  logic          busy_a, done_a, err_a, busy_r, done_r, err_r;

  always #5 clk = ~clk;

  pc_sequencer #(.D(D), .LW(LW), .SD(SD), .REL(0), .START_PC(0), .HALT_PC(HALT)) u_abs (
    .clk(clk), .reset(reset), .req(req), .stall(stall), .branch(branch), .call(call),
    .ret(ret), .halt(halt), .lut_idx(lut_idx), .lut_wr_en(lut_wr_en),
    .lut_wr_idx(lut_wr_idx), .lut_wr_data(lut_wr_data),
    .prog_ctr(pc_a), .busy(busy_a), .done(done_a), .stack_err(err_a));

  pc_sequencer #(.D(D), .LW(LW), .SD(SD), .REL(1), .START_PC(0), .HALT_PC(HALT)) u_rel (
    .clk(clk), .reset(reset), .req(req), .stall(stall), .branch(branch), .call(call),
    .ret(ret), .halt(halt), .lut_idx(lut_idx), .lut_wr_en(lut_wr_en),
    .lut_wr_idx(lut_wr_idx), .lut_wr_data(lut_wr_data),
    .prog_ctr(pc_r), .busy(busy_r), .done(done_r), .stack_err(err_r));

  int checks = 0, errors = 0;

  // Model: 0 = idle, 1 = running, 2 = done; index 0 absolute, 1 relative.
  int m_st[2], m_pc[2];
  bit m_err[2];
  int m_stk0[$], m_stk1[$];
  int m_lut[8];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    for (int r = 0; r < 2; r++) begin
      m_st[r] = 0; m_pc[r] = 0; m_err[r] = 0;
    end
    m_stk0.delete(); m_stk1.delete();
    for (int i = 0; i < 8; i++) m_lut[i] = 0;
  endtask

  task automatic model_one(input int r, inout int q[$]);
    int tgt, off;
    if (m_st[r] != 1) begin
      if (req) begin
        m_st[r] = 1; m_pc[r] = 0; m_err[r] = 0; q.delete();
      end
    end else if (m_pc[r] == HALT || (halt && !stall)) begin
      m_st[r] = 2;
    end else if (!stall) begin
      off = m_lut[lut_idx];
      if (r == 1) begin
        if (off >= MOD / 2) off = off - MOD;
        tgt = ((m_pc[r] + off) % MOD + MOD) % MOD;
      end else begin
        tgt = off;
      end
      if (ret) begin
        if (q.size() > 0) m_pc[r] = q.pop_back();
        else begin m_err[r] = 1; m_pc[r] = (m_pc[r] + 1) % MOD; end
      end else if (call) begin
        if (q.size() < SD) begin q.push_back((m_pc[r] + 1) % MOD); m_pc[r] = tgt; end
        else begin m_err[r] = 1; m_pc[r] = (m_pc[r] + 1) % MOD; end
      end else if (branch) begin
        m_pc[r] = tgt;
      end else begin
        m_pc[r] = (m_pc[r] + 1) % MOD;
      end
    end
  endtask

  task automatic model_step();
    model_one(0, m_stk0);
    model_one(1, m_stk1);
    if (lut_wr_en) m_lut[lut_wr_idx] = int'(lut_wr_data);
  endtask

  task automatic compare();
    check("pc_abs",   pc_a,   m_pc[0]);
    check("busy_abs", busy_a, m_st[0] == 1);
    check("done_abs", done_a, m_st[0] == 2);
    check("err_abs",  err_a,  m_err[0]);
    check("pc_rel",   pc_r,   m_pc[1]);
    check("busy_rel", busy_r, m_st[1] == 1);
    check("done_rel", done_r, m_st[1] == 2);
    check("err_rel",  err_r,  m_err[1]);
  endtask

  task automatic cycle();
    @(posedge clk);
    model_step();
    #1;
    compare();
  endtask

  task automatic clear_in();
    req = 0; stall = 0; branch = 0; call = 0; ret = 0; halt = 0;
    lut_idx = '0; lut_wr_en = 0; lut_wr_idx = '0; lut_wr_data = '0;
  endtask

  task automatic do_reset();
    clear_in();
    @(negedge clk);
    reset = 0;
    #1;
    model_reset();
    compare();
    @(negedge clk);
    reset = 1;
  endtask

  task automatic start(input int widx, input int wdat);
    req = 1; lut_wr_en = 1; lut_wr_idx = LW'(widx); lut_wr_data = D'(wdat);
    cycle();
    clear_in();
  endtask

  task automatic run_to(input int target);
    int budget = 2 * MOD;
    while (pc_a != D'(target) && budget > 0) begin
      cycle();
      budget--;
    end
    if (budget == 0) begin
      checks++; errors++;
      $display("FAIL run_to: pc %0d never reached %0d", pc_a, target);
    end
  endtask

  typedef struct {
    bit rq, st, br, ca, re, ha;
    int idx;
    bit wr;
    int widx, wdat, pc;
    bit bz, dn, er;
  } vec_t;

  function automatic vec_t mk(input bit rq, st, br, ca, re, ha, input int idx,
                              input bit wr, input int widx, wdat, pc, input bit bz, dn, er);
    vec_t v;
    v.rq = rq; v.st = st; v.br = br; v.ca = ca; v.re = re; v.ha = ha; v.idx = idx;
    v.wr = wr; v.widx = widx; v.wdat = wdat; v.pc = pc; v.bz = bz; v.dn = dn; v.er = er;
    return v;
  endfunction

  vec_t tbl[$];

  initial begin
    #2ms;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog");
  end

  initial begin
    //           rq st br ca re ha idx wr widx wdat   pc  bz dn er
    tbl.push_back(mk(1, 0, 0, 0, 0, 0, 0, 1, 2, 40,   0,  1, 0, 0));
    tbl.push_back(mk(0, 0, 0, 0, 0, 0, 0, 1, 1, 20,   1,  1, 0, 0));
    tbl.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0,    2,  1, 0, 0));
    tbl.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0,    3,  1, 0, 0));
    tbl.push_back(mk(0, 0, 0, 1, 0, 0, 1, 0, 0, 0,   20,  1, 0, 0));
    for (int k = 21; k <= 25; k++)
      tbl.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, k, 1, 0, 0));
    tbl.push_back(mk(0, 0, 0, 0, 1, 0, 0, 0, 0, 0,    4,  1, 0, 0));
    tbl.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0,    5,  1, 0, 0));
    tbl.push_back(mk(0, 0, 1, 0, 0, 0, 2, 0, 0, 0,   40,  1, 0, 0));
    tbl.push_back(mk(0, 1, 1, 0, 0, 0, 1, 0, 0, 0,   40,  1, 0, 0));
    tbl.push_back(mk(0, 1, 1, 0, 0, 0, 1, 0, 0, 0,   40,  1, 0, 0));
    tbl.push_back(mk(0, 0, 1, 0, 0, 0, 1, 0, 0, 0,   20,  1, 0, 0));
    tbl.push_back(mk(0, 0, 0, 0, 1, 0, 0, 0, 0, 0,   21,  1, 0, 1));
    tbl.push_back(mk(0, 0, 0, 0, 0, 1, 0, 0, 0, 0,   21,  0, 1, 1));
    tbl.push_back(mk(1, 0, 0, 0, 0, 0, 0, 0, 0, 0,    0,  1, 0, 0));
    tbl.push_back(mk(0, 0, 1, 0, 0, 0, 5, 1, 5, 77,   0,  1, 0, 0));
    tbl.push_back(mk(0, 0, 1, 0, 0, 0, 5, 0, 0, 0,   77,  1, 0, 0));

    do_reset();
    foreach (tbl[i]) begin
      req = tbl[i].rq; stall = tbl[i].st; branch = tbl[i].br; call = tbl[i].ca;
      ret = tbl[i].re; halt = tbl[i].ha; lut_idx = LW'(tbl[i].idx);
      lut_wr_en = tbl[i].wr; lut_wr_idx = LW'(tbl[i].widx); lut_wr_data = D'(tbl[i].wdat);
      cycle();
      check($sformatf("tbl%0d_pc", i),   pc_a,   tbl[i].pc);
      check($sformatf("tbl%0d_busy", i), busy_a, tbl[i].bz);
      check($sformatf("tbl%0d_done", i), done_a, tbl[i].dn);
      check($sformatf("tbl%0d_err", i),  err_a,  tbl[i].er);
    end
    clear_in();

    // Free run to HALT_PC.
    do_reset();
    start(0, 0);
    check("t1_pc0", pc_a, 0);
    for (int k = 1; k <= HALT; k++) begin
      cycle();
      check("t1_count", pc_a, k);
      check("t1_busy", busy_a, 1);
    end
    cycle();
    check("t1_done", done_a, 1);
    check("t1_busy_low", busy_a, 0);
    check("t1_pc_hold", pc_a, HALT);
    cycle();
    check("t1_pc_hold2", pc_a, HALT);

    // Relative offset of -3.
    do_reset();
    start(2, 'h3FD);
    run_to(10);
    branch = 1; lut_idx = 2;
    cycle();
    clear_in();
    check("t2_abs_target", pc_a, 'h3FD);
    check("t2_rel_target", pc_r, 7);

    // Stack overflow and drain.
    do_reset();
    start(3, 100);
    call = 1; lut_idx = 3;
    for (int k = 0; k < SD; k++) begin
      cycle();
      check("t3_call_pc", pc_a, 100);
      check("t3_call_err", err_a, 0);
    end
    cycle();
    check("t3_ovf_pc", pc_a, 101);
    check("t3_ovf_err", err_a, 1);
    clear_in();
    ret = 1;
    for (int k = 0; k < SD; k++) cycle();
    check("t3_last_pop", pc_a, 1);
    cycle();
    check("t3_empty_ret", pc_a, 2);
    check("t3_err_sticky", err_a, 1);
    clear_in();

    // Underflow on a fresh run.
    do_reset();
    start(0, 0);
    ret = 1;
    cycle();
    clear_in();
    check("t3_udf_pc", pc_a, 1);
    check("t3_udf_err", err_a, 1);

    // Stall holds PC while branch is asserted.
    do_reset();
    start(4, 300);
    run_to(6);
    stall = 1; branch = 1; lut_idx = 4;
    repeat (3) begin
      cycle();
      check("t4_stall_pc", pc_a, 6);
    end
    stall = 0;
    cycle();
    clear_in();
    check("t4_release_pc", pc_a, 300);
    // halt under stall does not complete.
    stall = 1; halt = 1;
    cycle();
    clear_in();
    check("t4_halt_stalled", busy_a, 1);

    // halt beats call; req from DONE restarts.
    do_reset();
    start(1, 20);
    ret = 1;
    cycle();
    clear_in();
    run_to(9);
    halt = 1; call = 1; lut_idx = 1;
    cycle();
    clear_in();
    check("t5_done", done_a, 1);
    check("t5_pc", pc_a, 9);
    check("t5_err_held", err_a, 1);
    req = 1;
    cycle();
    clear_in();
    check("t5_restart_pc", pc_a, 0);
    check("t5_restart_busy", busy_a, 1);
    check("t5_restart_done", done_a, 0);
    check("t5_restart_err", err_a, 0);

    // HALT_PC completes even when stalled.
    run_to(HALT);
    stall = 1;
    cycle();
    clear_in();
    check("t5_halt_pc_stall", done_a, 1);

    // Asynchronous reset mid-run.
    do_reset();
    start(2, 40);
    run_to(50);
    #2;
    reset = 0;
    #1;
    model_reset();
    check("t6_pc", pc_a, 0);
    check("t6_busy", busy_a, 0);
    check("t6_done", done_a, 0);
    @(negedge clk);
    reset = 1;
    start(0, 0);
    branch = 1; lut_idx = 2;
    cycle();
    clear_in();
    check("t6_lut_cleared", pc_a, 0);

    // Randomized traffic against the model.
    do_reset();
    for (int n = 0; n < 4000; n++) begin
      req = ($urandom % 8) == 0;
      stall = ($urandom % 5) == 0;
      branch = ($urandom % 6) == 0;
      call = ($urandom % 8) == 0;
      ret = ($urandom % 8) == 0;
      halt = ($urandom % 60) == 0;
      lut_idx = LW'($urandom);
      lut_wr_en = ($urandom % 4) == 0;
      lut_wr_idx = LW'($urandom);
      lut_wr_data = ($urandom % 2) ? D'($urandom_range(0, 200)) : D'($urandom);
      cycle();
    end
    clear_in();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
